sales_ledger: RTL and testbench
===============================

# sales_ledger

Upstream bookkeeping stage of the vending-machine sales path. Accepts one completed-sale record per handshake, keeps saturating running totals (revenue, sale count, per-item counts) and, on an administrator total-view request, freezes a snapshot and raises `total_out` for the downstream total-sales display stage. Sales continue to be logged while the snapshot is shown.

## Interface
Parameters:
- `NUM_ITEMS`, 4: number of item slots; `sale_item` width = clog2(NUM_ITEMS)
- `PRICE_W`, 5: sale price width, whole yuan
- `TOTAL_MAX`, 9999: revenue saturation ceiling; `TOTAL_W` = 14
- `CNT_W`, 8: width of sale and per-item counters

Ports (one clock `clk`; reset `rst` is asynchronous and active-high):
- `clk`  in  1  system clock
- `rst`  in  1  async active-high reset
- `sale_valid`  in  1  sale record present
- `sale_item`  in  clog2(NUM_ITEMS)  item slot sold
- `sale_price`  in  PRICE_W  price charged
- `sale_ready`  out  1  ledger can accept a record this cycle
- `total_req`  in  1  level, admin switch "show total sales"
- `clear_req`  in  1  single-cycle pulse, zero all totals
- `total_out`  out  1  snapshot valid / display enable for downstream stage
- `disp_amount`  out  TOTAL_W  frozen revenue snapshot
- `disp_count`  out  CNT_W  frozen sale-count snapshot
- `sat_flag`  out  1  sticky: any counter has saturated since last clear

## Operation
- FSM states: IDLE, ACCUM, CLEAR.
- IDLE: `sale_ready`=1 unless `clear_req`=1. Accept when `sale_valid && sale_ready`; latch item/price into pending regs -> ACCUM. `clear_req`=1 -> CLEAR (takes priority; simultaneous sale not accepted).
- ACCUM (1 cycle, `sale_ready`=0): revenue += price, clamp to TOTAL_MAX; sale count +1, clamp to 2^CNT_W-1; item count[item] +1, clamp likewise. Any clamp sets `sat_flag`. `clear_req` here is ignored (not queued); -> IDLE.
- CLEAR (1 cycle, `sale_ready`=0): zero revenue, sale count, all item counts, `sat_flag` -> IDLE.
- Revenue add done at TOTAL_W+1 bits, compare against TOTAL_MAX before write-back; no wrap-around anywhere.
- View path independent of FSM: rising edge of `total_req` (registered previous value) captures live revenue/count into `disp_amount`/`disp_count` and sets `total_out`. Snapshot held constant while `total_req` stays high, even as sales accumulate. `total_req` low -> `total_out`=0 next edge; `disp_*` retain last value.
- Snapshot capture coincident with ACCUM write: capture pre-update values.
- Clear while showing: snapshot unaffected; new snapshot only on next `total_req` rise.

## Timing
- Reset: FSM=IDLE, `sale_ready`=1, `total_out`=0, `disp_amount`=0, `disp_count`=0, `sat_flag`=0, all internal counters 0, `total_req` edge register 0 (switch already high at reset release produces a capture on first edge).
- Sale throughput: one per 2 cycles; totals updated at 2nd edge after acceptance edge.
- `total_out` rises 1 cycle after `total_req` rises; falls 1 cycle after it falls.
- Clear: totals read 0 one edge after the CLEAR state is entered.
- Reset mid-ACCUM: pending sale discarded.

## Structure
- Shared package `vend_pkg`: FSM state enum, TOTAL_MAX, item-index type, price width constants (shared with the pricing and display stages).
- One natural sub-module: `sat_counter` (parameterised width/ceiling, inc-by-N, clear, saturated flag), instanced for revenue, sale count, and per-item counts.
- Edge detector and snapshot registers inline.

## Test plan
- Reset, then sales (item 0, 3), (item 2, 5), (item 0, 3) -> raise `total_req` -> `total_out`=1 next cycle, `disp_amount`=11, `disp_count`=3, item0 count 2.
- `sale_valid` held high continuously -> `sale_ready` toggles 1/0, exactly one sale logged per 2 cycles.
- Preload revenue 9990, sale price 20 -> revenue 9999, `sat_flag`=1; further sale stays 9999.
- `total_req` high, snapshot 11; log sale price 7 -> `disp_amount` stays 11; drop and raise `total_req` -> 18.
- `clear_req` with `sale_valid` same cycle in IDLE -> sale not accepted, totals 0, `sat_flag`=0; `clear_req` during ACCUM -> ignored, sale counted.
- Assert `rst` in ACCUM mid-sale -> all outputs at reset values immediately, pending sale not counted.

Source files
------------

// File: rtl/vend_pkg.sv
// Shared vending-path definitions: ledger FSM states, item index type, price/total widths.
// Used by the pricing, ledger and display stages so all agree on field sizes.
// Constants only; no logic.
package vend_pkg;

  localparam int NUM_ITEMS = 4;
  localparam int ITEM_W    = $clog2(NUM_ITEMS);
  localparam int PRICE_W   = 5;
  localparam int TOTAL_MAX = 9999;
  localparam int TOTAL_W   = 14;
  localparam int CNT_W     = 8;

  typedef logic [ITEM_W-1:0] item_idx_t;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ACCUM = 2'd1,
    ST_CLEAR = 2'd2
  } ledger_state_t;

endpackage

// File: rtl/sat_counter.sv
// Saturating accumulator: adds inc_val_i when inc_i, clamps at MAX, synchronous clear.
// Latency: count_o reflects an increment or clear one edge later.
// sat_o pulses combinationally in the cycle an increment would exceed MAX.
module sat_counter #(
  parameter int W     = 8,
  parameter int MAX   = 255,
  parameter int INC_W = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             inc_i,
  input  logic [INC_W-1:0] inc_val_i,
  input  logic             clr_i,
  output logic [W-1:0]     count_o,
  output logic             sat_o
);

  // One extra bit of headroom so the sum never wraps before the ceiling compare.
  localparam logic [W:0] MAX_V = (W+1)'(MAX);

  logic [W-1:0] count_q, count_d;
  logic [W:0]   sum;

  // Next count: clear wins, otherwise add and clamp at the ceiling.
  always_comb begin
    sum     = {1'b0, count_q} + (W+1)'(inc_val_i);
    count_d = count_q;
    sat_o   = 1'b0;
    if (clr_i) begin
      count_d = '0;
    end else if (inc_i) begin
      if (sum > MAX_V) begin
        count_d = MAX_V[W-1:0];
        sat_o   = 1'b1;
      end else begin
        count_d = sum[W-1:0];
      end
    end
  end

  // Count register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) count_q <= '0;
    else     count_q <= count_d;
  end

  assign count_o = count_q;

endmodule

// File: rtl/sales_ledger.sv
// Sales ledger: logs one sale per handshake into saturating totals; snapshots totals for display.
// Latency: totals update one edge after the accept edge; total_out follows total_req by one edge.
// sale_ready drops for the accumulate/clear cycle, so at most one sale per two cycles.
module sales_ledger
  import vend_pkg::*;
#(
  parameter int NUM_ITEMS = vend_pkg::NUM_ITEMS,
  parameter int ITEM_W    = $clog2(NUM_ITEMS),
  parameter int PRICE_W   = vend_pkg::PRICE_W,
  parameter int TOTAL_MAX = vend_pkg::TOTAL_MAX,
  parameter int TOTAL_W   = vend_pkg::TOTAL_W,
  parameter int CNT_W     = vend_pkg::CNT_W
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               sale_valid,
  input  logic [ITEM_W-1:0]  sale_item,
  input  logic [PRICE_W-1:0] sale_price,
  output logic               sale_ready,
  input  logic               total_req,
  input  logic               clear_req,
  output logic               total_out,
  output logic [TOTAL_W-1:0] disp_amount,
  output logic [CNT_W-1:0]   disp_count,
  output logic               sat_flag
);

  localparam int CNT_MAX = (1 << CNT_W) - 1;

  ledger_state_t      state_q, state_d;
  logic [ITEM_W-1:0]  item_q, item_d;
  logic [PRICE_W-1:0] price_q, price_d;
  logic               sat_flag_q, sat_flag_d;
  logic               req_q;
  logic               total_out_q;
  logic [TOTAL_W-1:0] disp_amount_q;
  logic [CNT_W-1:0]   disp_count_q;

  logic               do_inc, do_clr;
  logic [TOTAL_W-1:0] rev_cnt;
  logic [CNT_W-1:0]   sale_cnt;
  logic [CNT_W-1:0]   item_cnt [NUM_ITEMS];
  logic               rev_sat, cnt_sat;
  logic [NUM_ITEMS-1:0] item_sat;
  logic               sat_any;

  // FSM next state, handshake and pending-sale capture; clear beats a coincident sale.
  always_comb begin
    state_d    = state_q;
    item_d     = item_q;
    price_d    = price_q;
    sale_ready = 1'b0;
    do_inc     = 1'b0;
    do_clr     = 1'b0;
    case (state_q)
      ST_IDLE: begin
        sale_ready = ~clear_req;
        if (clear_req) begin
          state_d = ST_CLEAR;
        end else if (sale_valid) begin
          item_d  = sale_item;
          price_d = sale_price;
          state_d = ST_ACCUM;
        end
      end
      ST_ACCUM: begin
        do_inc  = 1'b1;
        state_d = ST_IDLE;
      end
      ST_CLEAR: begin
        do_clr  = 1'b1;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // FSM state and pending sale registers; reset drops any sale in flight.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      item_q  <= '0;
      price_q <= '0;
    end else begin
      state_q <= state_d;
      item_q  <= item_d;
      price_q <= price_d;
    end
  end

  sat_counter #(.W(TOTAL_W), .MAX(TOTAL_MAX), .INC_W(PRICE_W)) u_rev (
    .clk(clk), .rst(rst), .inc_i(do_inc), .inc_val_i(price_q),
    .clr_i(do_clr), .count_o(rev_cnt), .sat_o(rev_sat)
  );

  sat_counter #(.W(CNT_W), .MAX(CNT_MAX), .INC_W(1)) u_sales (
    .clk(clk), .rst(rst), .inc_i(do_inc), .inc_val_i(1'b1),
    .clr_i(do_clr), .count_o(sale_cnt), .sat_o(cnt_sat)
  );

  for (genvar i = 0; i < NUM_ITEMS; i++) begin : g_item
    sat_counter #(.W(CNT_W), .MAX(CNT_MAX), .INC_W(1)) u_cnt (
      .clk(clk), .rst(rst), .inc_i(do_inc && (item_q == ITEM_W'(i))), .inc_val_i(1'b1),
      .clr_i(do_clr), .count_o(item_cnt[i]), .sat_o(item_sat[i])
    );
  end

  // Sticky saturation indication, cleared only by the clear cycle.
  always_comb begin
    sat_any    = rev_sat | cnt_sat | (|item_sat);
    sat_flag_d = do_clr ? 1'b0 : (sat_flag_q | sat_any);
  end

  // Saturation flag register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) sat_flag_q <= 1'b0;
    else     sat_flag_q <= sat_flag_d;
  end

  // View path: capture live totals on a total_req rise (pre-update values if an
  // accumulate lands on the same edge); display enable simply follows the switch.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      req_q         <= 1'b0;
      total_out_q   <= 1'b0;
      disp_amount_q <= '0;
      disp_count_q  <= '0;
    end else begin
      req_q       <= total_req;
      total_out_q <= total_req;
      if (total_req && !req_q) begin
        disp_amount_q <= rev_cnt;
        disp_count_q  <= sale_cnt;
      end
    end
  end

  assign total_out   = total_out_q;
  assign disp_amount = disp_amount_q;
  assign disp_count  = disp_count_q;
  assign sat_flag    = sat_flag_q;

endmodule

// File: tb/tb_sales_ledger.sv
module tb_sales_ledger;

  logic        clk;
  logic        rst;
  logic        sale_valid;
  logic [1:0]  sale_item;
  logic [4:0]  sale_price;
  logic        sale_ready;
  logic        total_req;
  logic        clear_req;
  logic        total_out;
  logic [13:0] disp_amount;
  logic [7:0]  disp_count;
  logic        sat_flag;

  int n_assert = 0;
  int n_fail   = 0;

  sales_ledger dut (
    .clk(clk), .rst(rst),
    .sale_valid(sale_valid), .sale_item(sale_item), .sale_price(sale_price),
    .sale_ready(sale_ready), .total_req(total_req), .clear_req(clear_req),
    .total_out(total_out), .disp_amount(disp_amount), .disp_count(disp_count),
    .sat_flag(sat_flag)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Full handshake: wait for ready (bounded), present for one edge, let ACCUM finish.
  task automatic do_sale(input logic [1:0] item, input logic [4:0] price);
    int waited = 0;
    while (!sale_ready && waited < 10) begin
      step();
      waited++;
    end
    if (!sale_ready) chk("sale_ready_timeout", 32'(sale_ready), 32'd1);
    sale_valid = 1'b1;
    sale_item  = item;
    sale_price = price;
    step();
    sale_valid = 1'b0;
    step();
  endtask

  // Raise the view switch, check the snapshot, drop it again.
  task automatic show(input string tag, input logic [13:0] amt, input logic [7:0] cnt);
    total_req = 1'b1;
    step();
    chk({tag, "_total_out"}, 32'(total_out), 32'd1);
    chk({tag, "_amount"}, 32'(disp_amount), 32'(amt));
    chk({tag, "_count"}, 32'(disp_count), 32'(cnt));
    total_req = 1'b0;
    step();
  endtask

  task automatic pulse_clear();
    clear_req = 1'b1;
    step();
    clear_req = 1'b0;
    step();
  endtask

  initial begin
    rst        = 1'b1;
    sale_valid = 1'b0;
    sale_item  = '0;
    sale_price = '0;
    total_req  = 1'b0;
    clear_req  = 1'b0;
    #2;
    chk("rst_sale_ready", 32'(sale_ready), 32'd1);
    chk("rst_total_out", 32'(total_out), 32'd0);
    chk("rst_disp_amount", 32'(disp_amount), 32'd0);
    chk("rst_disp_count", 32'(disp_count), 32'd0);
    chk("rst_sat_flag", 32'(sat_flag), 32'd0);
    #10 rst = 1'b0;
    step();

    // Basic totals: 3 + 5 + 3.
    do_sale(2'd0, 5'd3);
    do_sale(2'd2, 5'd5);
    do_sale(2'd0, 5'd3);
    show("basic", 14'd11, 8'd3);
    chk("basic_item0", 32'(dut.item_cnt[0]), 32'd2);
    chk("basic_item2", 32'(dut.item_cnt[2]), 32'd1);
    chk("basic_off", 32'(total_out), 32'd0);

    // sale_valid held high: ready alternates, one sale per two cycles.
    sale_valid = 1'b1;
    sale_item  = 2'd1;
    sale_price = 5'd1;
    for (int k = 0; k < 6; k++) begin
      chk($sformatf("stream_ready_%0d", k), 32'(sale_ready), 32'((k % 2) == 0));
      if (k == 5) sale_valid = 1'b0;
      step();
    end
    sale_valid = 1'b0;
    show("stream", 14'd14, 8'd6);
    chk("stream_item1", 32'(dut.item_cnt[1]), 32'd3);

    // Clear coincident with a sale in IDLE: clear wins, sale dropped.
    clear_req  = 1'b1;
    sale_valid = 1'b1;
    sale_item  = 2'd3;
    sale_price = 5'd9;
    #1;
    chk("clr_sale_ready", 32'(sale_ready), 32'd0);
    step();
    clear_req  = 1'b0;
    sale_valid = 1'b0;
    step();
    show("clr", 14'd0, 8'd0);
    chk("clr_item0", 32'(dut.item_cnt[0]), 32'd0);
    chk("clr_item3", 32'(dut.item_cnt[3]), 32'd0);

    // Snapshot frozen while switch stays high.
    do_sale(2'd0, 5'd3);
    do_sale(2'd2, 5'd5);
    do_sale(2'd0, 5'd3);
    total_req = 1'b1;
    step();
    chk("hold_first", 32'(disp_amount), 32'd11);
    do_sale(2'd1, 5'd7);
    chk("hold_frozen_amt", 32'(disp_amount), 32'd11);
    chk("hold_frozen_cnt", 32'(disp_count), 32'd3);
    chk("hold_still_on", 32'(total_out), 32'd1);
    total_req = 1'b0;
    step();
    chk("hold_drop_out", 32'(total_out), 32'd0);
    chk("hold_drop_retain", 32'(disp_amount), 32'd11);
    show("hold_reraise", 14'd18, 8'd4);

    // Clear during ACCUM is ignored and the sale counts.
    sale_valid = 1'b1;
    sale_item  = 2'd3;
    sale_price = 5'd2;
    step();
    sale_valid = 1'b0;
    clear_req  = 1'b1;
    step();
    clear_req  = 1'b0;
    step();
    show("accum_clr", 14'd20, 8'd5);
    chk("accum_clr_item3", 32'(dut.item_cnt[3]), 32'd1);

    // Saturation: sale count ceiling then revenue ceiling.
    pulse_clear();
    for (int k = 0; k < 255; k++) do_sale(2'(k % 4), 5'd31);
    chk("cnt255_no_sat", 32'(sat_flag), 32'd0);
    show("cnt255", 14'd7905, 8'd255);
    do_sale(2'd0, 5'd31);
    chk("cnt256_sat", 32'(sat_flag), 32'd1);
    show("cnt256", 14'd7936, 8'd255);
    for (int k = 0; k < 66; k++) do_sale(2'(k % 4), 5'd31);
    do_sale(2'd1, 5'd8);
    show("rev9990", 14'd9990, 8'd255);
    do_sale(2'd2, 5'd20);
    show("rev_clamp", 14'd9999, 8'd255);
    do_sale(2'd3, 5'd31);
    show("rev_stay", 14'd9999, 8'd255);
    chk("rev_sat_flag", 32'(sat_flag), 32'd1);
    pulse_clear();
    chk("sat_cleared", 32'(sat_flag), 32'd0);
    show("sat_clr_totals", 14'd0, 8'd0);

    // Reset in the middle of ACCUM.
    do_sale(2'd0, 5'd5);
    total_req = 1'b1;
    step();
    chk("pre_rst_amt", 32'(disp_amount), 32'd5);
    sale_valid = 1'b1;
    sale_item  = 2'd1;
    sale_price = 5'd9;
    step();
    sale_valid = 1'b0;
    rst = 1'b1;
    #1;
    chk("mid_rst_total_out", 32'(total_out), 32'd0);
    chk("mid_rst_amount", 32'(disp_amount), 32'd0);
    chk("mid_rst_ready", 32'(sale_ready), 32'd1);
    chk("mid_rst_sat", 32'(sat_flag), 32'd0);
    #2 rst = 1'b0;
    step();
    chk("post_rst_capture_out", 32'(total_out), 32'd1);
    chk("post_rst_amount", 32'(disp_amount), 32'd0);
    chk("post_rst_count", 32'(disp_count), 32'd0);
    total_req = 1'b0;
    step();

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
